// File: rtl/sdp_stream_reader.sv
// Burst reader for the single-clock simple-dual-port RAM: issues len reads from base_addr
// and replays the returned words as a valid/ready stream through a small skid FIFO.
module sdp_stream_reader #(
    parameter int AW         = 4,
    parameter int DW         = 2,
    parameter int RD_LAT     = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          ram_ren,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_dout,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic [1:0]    dbg_state
);

    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam int OW = $clog2(SKID_DEPTH + RD_LAT + 2);

    generate
        if (SKID_DEPTH < RD_LAT + 1 || RD_LAT < 1) begin : g_depth_check
            $error("sdp_stream_reader: SKID_DEPTH must be >= RD_LAT + 1 and RD_LAT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]     base_q;
    logic [AW:0]       len_q;
    logic [AW:0]       issued_q;
    logic [AW:0]       popped_q;
    logic [AW:0]       last_idx;
    logic [RD_LAT-1:0] ren_pipe;

    logic [DW-1:0]     fifo_mem [SKID_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;

    logic              issue;
    logic [AW-1:0]     issue_addr;
    logic [OW-1:0]     occ_next;
    logic              push;
    logic              pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Valid/ready: a beat transfers in every cycle where m_valid & m_ready are both high;
    // m_data and m_last come straight from the FIFO head register and cannot change while stalled.
    assign push     = ren_pipe[RD_LAT-1];
    assign m_valid  = (count_q != '0);
    assign pop      = m_valid & m_ready;
    assign m_data   = fifo_mem[rd_ptr];
    assign last_idx = len_q - 1'b1;
    assign m_last   = m_valid && (popped_q == last_idx);

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

    // Words that will be held or owed to the FIFO next cycle if no new read is issued:
    // current entries, reads still in the RAM pipeline, the read on the RAM port now, minus a pop.
    always_comb begin
        occ_next = OW'(count_q) + OW'(ram_ren);
        for (int i = 0; i < RD_LAT; i++) begin
            occ_next = occ_next + OW'(ren_pipe[i]);
        end
        if (pop) begin
            occ_next = occ_next - OW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_addr = base_q + issued_q[AW-1:0];
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d    = S_RUN;
                        issue      = 1'b1;
                        issue_addr = base_addr;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                issue = (issued_q < len_q) && (occ_next < OW'(SKID_DEPTH));
                if (pop && m_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            ram_ren   <= 1'b0;
            ram_raddr <= '0;
            ren_pipe  <= '0;
        end else begin
            state_q     <= state_d;
            ram_ren     <= issue;
            ren_pipe[0] <= ram_ren;
            for (int i = 1; i < RD_LAT; i++) begin
                ren_pipe[i] <= ren_pipe[i-1];
            end
            if (issue) begin
                ram_raddr <= issue_addr;
            end
            if (pop) begin
                popped_q <= popped_q + 1'b1;
            end
            if (state_q == S_IDLE && start) begin
                base_q   <= base_addr;
                len_q    <= len;
                popped_q <= '0;
                issued_q <= issue ? {{AW{1'b0}}, 1'b1} : '0;
            end else if (issue) begin
                issued_q <= issued_q + 1'b1;
            end
        end
    end

    // At full, a push can only coincide with a pop, so wr_ptr == rd_ptr overwrites the outgoing head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ram_dout;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count_q == CW'(SKID_DEPTH)));
        end
    end

endmodule

// File: tb/tb_sdp_stream_reader.sv
// Bench for sdp_stream_reader: a 2-cycle registered RAM model, a burst table plus
// hand-written stall / ignored-start / mid-burst-reset sequences, and a beat scoreboard.
module tb_sdp_stream_reader;

    localparam int AW    = 4;
    localparam int DW    = 2;
    localparam int DEPTH = 16;

    typedef struct {
        int base;
        int len;
        int pct;
        int exp_done;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_stage;

    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];

    int vectors = 0;
    int fails = 0;
    int cyc = 0;
    int ready_pct = 100;
    bit hold = 1'b0;
    int ren_count = 0;
    int first_ren_cyc = -1;
    int first_valid_cyc = -1;
    bit prev_stall = 1'b0;
    int prev_beat = 0;

    vec_t vecs[7];

    sdp_stream_reader #(.AW(AW), .DW(DW), .RD_LAT(2), .SKID_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .dbg_state (dbg_state)
    );

    // clock / reset block and RAM model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i % 4);
        ram_stage = '0;
        ram_dout  = '0;
    end

    always @(posedge clk) begin
        if (ram_ren === 1'b1) ram_stage <= mem[ram_raddr];
        ram_dout <= ram_stage;
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = hold ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            if (ram_ren === 1'b1) begin
                ren_count++;
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
                if (addr_q.size() == 0) check("unexpected_ren", 1, 0);
                else check("raddr", int'(ram_raddr), int'(addr_q.pop_front()));
            end
            if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid", int'(m_valid), 1);
                check("stall_stable", int'({m_last, m_data}), prev_beat);
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else check("beat", int'({m_last, m_data}), int'(exp_q.pop_front()));
            end
            prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
            prev_beat  = int'({m_last, m_data});
        end
    end

    // driver tasks
    task automatic begin_burst(input int b, input int l, output int t0);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = AW'(b);
        len = (AW+1)'(l);
        t0 = cyc;
        first_ren_cyc = -1;
        first_valid_cyc = -1;
        ren_count = 0;
        for (int i = 0; i < l; i++) begin
            addr_q.push_back(AW'(b + i));
            exp_q.push_back({(i == l - 1), mem[(b + i) % DEPTH]});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int l, input int exp_done);
        int waited = 0;
        @(negedge clk);
        while (done !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", 0, 1);
        end else begin
            if (exp_done > 0) check("done_cycle", cyc - t0, exp_done);
            check("busy_at_done", int'(busy), 1);
            check("ren_count", ren_count, l);
            check("beats_left", exp_q.size(), 0);
            if (exp_done > 0 && l > 0) begin
                check("first_ren_cycle", first_ren_cyc - t0, 1);
                check("first_valid_cycle", first_valid_cyc - t0, 4);
            end
        end
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
    endtask

    task automatic run_hold(input int b, input int l);
        int t0;
        hold = 1'b1;
        ready_pct = 100;
        @(negedge clk);
        begin_burst(b, l, t0);
        repeat (13) @(negedge clk);
        check("hold_ren_count", ren_count, (l < 4) ? l : 4);
        check("hold_valid", int'(m_valid), 1);
        check("hold_head", int'(m_data), int'(mem[b % DEPTH]));
        check("hold_last", int'(m_last), int'(l == 1));
        hold = 1'b0;
        wait_done(t0, l, 0);
    endtask

    initial begin
        int t0;
        int valid_seen;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ren", int'(ram_ren), 0);
        check("rst_raddr", int'(ram_raddr), 0);
        check("rst_valid", int'(m_valid), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_last", int'(m_last), 0);
        check("rst_state", int'(dbg_state), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        vecs[0] = '{base: 0,  len: 4,  pct: 100, exp_done: 8};
        vecs[1] = '{base: 14, len: 4,  pct: 100, exp_done: 8};
        vecs[2] = '{base: 5,  len: 16, pct: 100, exp_done: 20};
        vecs[3] = '{base: 0,  len: 0,  pct: 100, exp_done: 1};
        vecs[4] = '{base: 7,  len: 16, pct: 30,  exp_done: 0};
        vecs[5] = '{base: 9,  len: 1,  pct: 100, exp_done: 5};
        vecs[6] = '{base: 2,  len: 3,  pct: 60,  exp_done: 0};

        for (int k = 0; k < 7; k++) begin
            ready_pct = vecs[k].pct;
            @(negedge clk);
            begin_burst(vecs[k].base, vecs[k].len, t0);
            wait_done(t0, vecs[k].len, vecs[k].exp_done);
        end

        run_hold(0, 4);
        run_hold(0, 16);

        // start during RUN is ignored
        ready_pct = 100;
        @(negedge clk);
        begin_burst(2, 8, t0);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = AW'(10);
        len = (AW+1)'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(t0, 8, 12);

        // reset two cycles after the first read of a len=8 burst
        @(negedge clk);
        begin_burst(0, 8, t0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ren", int'(ram_ren), 0);
        check("mid_rst_raddr", int'(ram_raddr), 0);
        check("mid_rst_valid", int'(m_valid), 0);
        check("mid_rst_data", int'(m_data), 0);
        check("mid_rst_state", int'(dbg_state), 0);
        valid_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_valid !== 1'b0) valid_seen++;
        end
        check("stale_valid", valid_seen, 0);
        begin_burst(3, 2, t0);
        wait_done(t0, 2, 6);

        check("queue_empty", exp_q.size() + addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
